// File: rtl/router_fifo.sv
// router_fifo
// ----------------------------------------------------------------------------
// Packet FIFO for one router output port. Each stored word is a byte plus a
// header flag (bit WIDTH), set when the byte was written while the input FSM
// was in its load-first-data state. On the read side, a 7-bit packet counter
// tracks how many bytes of the current packet remain. The registered output
// returns to zero once a packet has drained and no read is pending.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous active-high reset, clears all state
//   soft_reset : synchronous active-high flush (per-output timeout)
//   write_enb  : write request for data_in this cycle
//   read_enb   : read request this cycle
//   lfd_state  : high when data_in is the packet header byte
//   data_in    : byte from the register stage
//   data_out   : registered read data
//   full       : DEPTH words stored (combinational)
//   empty      : no words stored (combinational)
// ----------------------------------------------------------------------------
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int ADDR = $clog2(DEPTH);
    localparam logic [ADDR:0] PTR_ONE = {{ADDR{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR:0]  wr_ptr;
    logic [ADDR:0]  rd_ptr;
    logic [WIDTH:0] mem [DEPTH];
    logic [6:0]     pkt_count;
    logic           write_ok;
    logic           read_ok;
    logic [WIDTH:0] rd_word;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr == {~rd_ptr[ADDR], rd_ptr[ADDR-1:0]});
    assign write_ok = write_enb && !full;
    assign read_ok  = read_enb && !empty;
    assign rd_word  = mem[rd_ptr[ADDR-1:0]];

    // Storage array is deliberately not reset; the pointers guarantee that
    // no unwritten word is ever read out.
    always_ff @(posedge clk) begin
        if (write_ok && !soft_reset && !reset) begin
            mem[wr_ptr[ADDR-1:0]] <= {lfd_state, data_in};
        end
    end

    // Write pointer. A flush takes priority over any write in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
        end else if (write_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Read pointer, packet counter and registered output.
    // The header byte carries the payload length in bits [7:2]. The counter
    // loads length+1 so that it also covers the trailing parity byte.
    // data_out is cleared only when idle with no packet in flight. This keeps
    // the last byte of a packet visible for one cycle after it is read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            pkt_count <= '0;
            data_out  <= '0;
        end else if (soft_reset) begin
            rd_ptr    <= '0;
            pkt_count <= '0;
            data_out  <= '0;
        end else if (read_ok) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            data_out <= rd_word[WIDTH-1:0];
            if (rd_word[WIDTH]) begin
                pkt_count <= {1'b0, rd_word[7:2]} + 7'd1;
            end else if (pkt_count != 7'd0) begin
                pkt_count <= pkt_count - 7'd1;
            end
        end else if (pkt_count == 7'd0) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for router_fifo. A queue holds the words the FIFO
// should contain, and a small packet-counter model predicts data_out.
// A table of single-cycle vectors covers the basic packet transfer. The
// multi-cycle corner cases are written out by hand: filling to full, full
// with simultaneous read and write, pointer wrap, soft flush, and
// asynchronous reset.
// ----------------------------------------------------------------------------
module tb_router_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [8:0] sb_q[$];
    logic [6:0] m_pkt;
    logic [7:0] m_dout;

    typedef struct {
        logic       we;
        logic       re;
        logic       lfd;
        logic [7:0] din;
        logic       exp_full;
        logic       exp_empty;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[11];

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_dout"},  {24'd0, data_out}, {24'd0, m_dout});
        checkVal({tag, "_full"},  {31'd0, full},     {31'd0, (sb_q.size() == DEPTH)});
        checkVal({tag, "_empty"}, {31'd0, empty},    {31'd0, (sb_q.size() == 0)});
    endtask

    // Drives one cycle of stimulus and updates the model at the edge.
    // Acceptance is decided from the model's pre-edge occupancy.
    task automatic applyStimulus(input logic we, input logic re, input logic lfd,
                                 input logic [7:0] din, input string tag);
        logic       w_acc;
        logic       r_acc;
        logic [8:0] word;
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = din;
        w_acc = we && (sb_q.size() < DEPTH);
        r_acc = re && (sb_q.size() > 0);
        @(posedge clk);
        #1;
        if (r_acc) begin
            word   = sb_q.pop_front();
            m_dout = word[7:0];
            if (word[8]) m_pkt = {1'b0, word[7:2]} + 7'd1;
            else if (m_pkt != 7'd0) m_pkt = m_pkt - 7'd1;
        end else if (m_pkt == 7'd0) begin
            m_dout = 8'h00;
        end
        if (w_acc) sb_q.push_back({lfd, din});
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
        checkOutput(tag);
    endtask

    task automatic clearModel();
        sb_q.delete();
        m_pkt  = 7'd0;
        m_dout = 8'h00;
    endtask

    task automatic resetDut();
        #2 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        clearModel();
    endtask

    initial begin
        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        clearModel();

        // Packet: header 0x0D (len 3), three payload bytes, parity 0x2C.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h2C, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h0D};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h2C};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00};

        // Outputs while reset is held, before any clock edge
        #2;
        checkVal("rst_empty", {31'd0, empty},    32'd1);
        checkVal("rst_full",  {31'd0, full},     32'd0);
        checkVal("rst_dout",  {24'd0, data_out}, 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;

        $display("[TB] basic packet vectors");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din, $sformatf("vec%0d", i));
            checkVal($sformatf("vec%0d_tbl_dout", i),  {24'd0, data_out}, {24'd0, vecs[i].exp_dout});
            checkVal($sformatf("vec%0d_tbl_full", i),  {31'd0, full},     {31'd0, vecs[i].exp_full});
            checkVal($sformatf("vec%0d_tbl_empty", i), {31'd0, empty},    {31'd0, vecs[i].exp_empty});
        end

        $display("[TB] fill to full, overflow write dropped");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i), $sformatf("fill%0d", i));
        checkVal("fill_full", {31'd0, full}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, "overflow");
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, $sformatf("drain%0d", i));
        checkVal("drain_empty", {31'd0, empty}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "drain_idle");

        $display("[TB] simultaneous read and write while full");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h80 + 8'(i), $sformatf("fill2_%0d", i));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA, "rw_full");
        checkVal("rw_full_dout", {24'd0, data_out}, 32'h80);
        checkVal("rw_full_flag", {31'd0, full},     32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hBB, "rw_both");
        checkVal("rw_both_dout", {24'd0, data_out}, 32'h81);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, $sformatf("drain2_%0d", i));
        checkVal("drain2_last", {24'd0, data_out}, 32'hBB);

        $display("[TB] pointer wrap with a straddling packet");
        resetDut();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i), $sformatf("pre_w%0d", i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, $sformatf("pre_r%0d", i));
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h28, "wrap_hdr");
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i), $sformatf("wrap_w%0d", i));
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, $sformatf("wrap_r%0d", i));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "wrap_hold");
        checkVal("wrap_hold_dout", {24'd0, data_out}, 32'hC4);
        for (int i = 6; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, $sformatf("wrap_r%0d", i));
        checkVal("wrap_last", {24'd0, data_out}, 32'hCA);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "wrap_idle");
        checkVal("wrap_idle_dout", {24'd0, data_out}, 32'h00);

        $display("[TB] soft reset with write pending");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h0D, "sr_w0");
        for (int i = 1; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i), $sformatf("sr_w%0d", i));
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "sr_r0");
        soft_reset = 1'b1;
        write_enb  = 1'b1;
        data_in    = 8'hEE;
        @(posedge clk);
        #1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        clearModel();
        checkOutput("soft_reset");
        checkVal("soft_reset_empty", {31'd0, empty}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h77, "sr_post_w");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "sr_post_r");
        checkVal("sr_post_dout", {24'd0, data_out}, 32'h77);

        $display("[TB] asynchronous reset mid-packet");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h0D, "ar_w0");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h11, "ar_w1");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h22, "ar_w2");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "ar_r0");
        #3 reset = 1'b1;
        #1;
        checkVal("async_empty", {31'd0, empty},    32'd1);
        checkVal("async_full",  {31'd0, full},     32'd0);
        checkVal("async_dout",  {24'd0, data_out}, 32'd0);
        clearModel();
        #2 reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h55, "post_rst_w");
        checkVal("post_rst_empty", {31'd0, empty}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "post_rst_r");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "post_rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of 9-bit storage words (header flag + data byte); must be a power of two.
REQ-002 Parameter WIDTH, default 8, payload byte width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 soft_reset  input  1  synchronous, active-high; flushes the FIFO (per-output timeout from sync block).
REQ-006 write_enb  input  1  write request for data_in this cycle.
REQ-007 read_enb  input  1  read request this cycle.
REQ-008 lfd_state  input  1  high when the written byte is the packet header; stored as flag bit 8.
REQ-009 data_in  input  WIDTH  byte from the register stage dout.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 full  output  1  combinational; high when DEPTH words are stored.
REQ-012 empty  output  1  combinational; high when 0 words are stored.

Function
REQ-013 The FIFO SHALL use write and read pointers of log2(DEPTH)+1 bits, the MSB being a wrap bit.
REQ-014 The FIFO SHALL assert empty when the pointers are equal and full when they differ only in the MSB.
REQ-015 An accepted write (write_enb && !full) SHALL store {lfd_state, data_in} at wr_ptr and increment wr_ptr modulo 2*DEPTH.
REQ-016 A write while full SHALL be dropped with no pointer, memory or flag change.
REQ-017 An accepted read (read_enb && !empty) SHALL load data_out with the stored byte at rd_ptr on the same edge (1-cycle latency) and increment rd_ptr modulo 2*DEPTH.
REQ-018 A read while empty SHALL leave rd_ptr unchanged; data_out then follows REQ-021.
REQ-019 Simultaneous write and read SHALL both proceed when neither is blocked; flags are evaluated from pre-edge pointers, so when full only the read proceeds and when empty only the write proceeds.
REQ-020 A 7-bit packet counter SHALL load (stored byte[7:2] + 1) on an accepted read of a word with flag=1, and decrement by 1 on an accepted read of a word with flag=0 when nonzero.
REQ-021 On any edge with no accepted read and counter equal to 0, data_out SHALL be driven to 0; otherwise data_out SHALL hold.
REQ-022 Reading a flag=0 word while the counter is 0 SHALL still output the byte; the counter stays 0.
REQ-023 soft_reset SHALL, on the next edge, zero both pointers, counter and data_out, overriding any write or read in that cycle; memory contents need not be cleared.
REQ-024 Pointer wrap-around SHALL be seamless: a packet straddling the last and first memory words reads back in order.
REQ-025 full and empty SHALL never be high together.

Reset
REQ-026 While reset is high: wr_ptr=0, rd_ptr=0, counter=0, data_out=0, empty=1, full=0, independent of clk.
REQ-027 Memory contents SHALL not be required to reset; no output may depend on unwritten memory.
REQ-028 Reset deassertion SHALL take effect at the first rising edge after release; a write on that edge is accepted.
REQ-029 Reset asserted mid-packet SHALL discard all stored words and the remaining packet count.

Verification
REQ-030 Write header 0x0D (len 3, addr 1, lfd_state=1), then 0x11,0x22,0x33, parity 0x2C; read 5 -> data_out 0x0D,0x11,0x22,0x33,0x2C each 1 cycle after read_enb; empty=1 after 5th read; data_out=0 on next idle edge.
REQ-031 16 consecutive writes -> full=1 after 16th; 17th write 0xFF dropped; 16 reads return the first 16 bytes in order; empty=1.
REQ-032 Fill to 16, assert write_enb and read_enb together -> read accepted, write dropped, full deasserts to 0 with 15 stored; then repeat -> both accepted, count stays 15.
REQ-033 Write 10, read 10, write 12-byte packet (header len 10) -> pointers wrap past word 15; all 12 bytes read back in order; counter reaches 0 on the last byte.
REQ-034 Write 5 words, pulse soft_reset with write_enb high -> empty=1, data_out=0, no word written.
REQ-035 Write 3 words, assert reset asynchronously between edges -> empty=1, data_out=0 immediately, before the next clk edge.
